// File: rtl/lpc_residual_decoder.sv
// LPC residual decoder: rebuilds PCM samples from warm-up samples plus residuals
// added to a quantised fixed-order linear prediction over the sample history.
module lpc_residual_decoder #(
  parameter int unsigned MAX_ORDER = 12,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned COEFF_W   = 12
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iEnable,
  input  logic                       iLoad,
  input  logic [3:0]                 iM,
  input  logic signed [COEFF_W-1:0]  iCoeff,
  input  logic                       iStart,
  input  logic [3:0]                 iOrder,
  input  logic [3:0]                 iShift,
  input  logic [15:0]                iBlockSize,
  input  logic                       iValid,
  input  logic signed [SAMPLE_W-1:0] iResidual,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                       oValid,
  output logic                       oDone,
  output logic                       oBusy
);

  localparam int unsigned PROD_W = SAMPLE_W + COEFF_W;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t                      state;
  logic signed [COEFF_W-1:0]   coeff [MAX_ORDER];
  logic signed [SAMPLE_W-1:0]  hist  [MAX_ORDER];
  logic [3:0]                  order_q;
  logic [3:0]                  shift_q;
  logic [CNT_W-1:0]            block_q;
  logic [CNT_W-1:0]            cnt;

  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     pred;
  logic signed [SAMPLE_W-1:0]  recon;
  logic signed [SAMPLE_W-1:0]  new_sample;
  logic [CNT_W-1:0]            cnt_next;
  logic                        start_ok;
  logic                        coeff_wr;

  // Single-cycle prediction from the registered history; taps beyond the order are masked.
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int j = 0; j < int'(MAX_ORDER); j++) begin
      prod = PROD_W'(coeff[j]) * PROD_W'(hist[j]);
      if (j < int'(order_q)) acc = acc + ACC_W'(prod);
    end
    pred       = acc >>> shift_q;
    recon      = iResidual + SAMPLE_W'(pred);
    new_sample = (state == WARMUP) ? iResidual : recon;
    cnt_next   = cnt + CNT_W'(1);
    start_ok   = (state == IDLE) && iStart && (iOrder <= 4'(MAX_ORDER)) &&
                 (iBlockSize != '0);
    coeff_wr   = iLoad && !oBusy && (iM >= 4'd1) && (iM <= 4'(MAX_ORDER));
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state   <= IDLE;
      order_q <= '0;
      shift_q <= '0;
      block_q <= '0;
      cnt     <= '0;
      oSample <= '0;
      oValid  <= 1'b0;
      oDone   <= 1'b0;
      oBusy   <= 1'b0;
      for (int k = 0; k < int'(MAX_ORDER); k++) begin
        coeff[k] <= '0;
        hist[k]  <= '0;
      end
    end else if (iEnable) begin
      oValid <= 1'b0;
      oDone  <= 1'b0;
      if (coeff_wr) coeff[iM - 4'd1] <= iCoeff;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= (iOrder != 4'd0) ? WARMUP : RUN;
            order_q <= iOrder;
            shift_q <= iShift;
            block_q <= iBlockSize;
            cnt     <= '0;
            oBusy   <= 1'b1;
            for (int k = 0; k < int'(MAX_ORDER); k++) hist[k] <= '0;
          end else begin
            oBusy <= 1'b0;
          end
        end
        default: begin
          if (iValid) begin
            oSample <= new_sample;
            oValid  <= 1'b1;
            cnt     <= cnt_next;
            hist[0] <= new_sample;
            for (int k = 1; k < int'(MAX_ORDER); k++) hist[k] <= hist[k-1];
            // Block end wins over the warm-up exit so short blocks finish in warm-up.
            if (cnt_next == block_q) begin
              oDone <= 1'b1;
              state <= IDLE;
            end else if ((state == WARMUP) && (cnt_next == CNT_W'(order_q))) begin
              state <= RUN;
            end
          end
        end
      endcase
    end else begin
      oValid <= 1'b0;
      oDone  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lpc_residual_decoder.sv
// Self-checking bench for lpc_residual_decoder: directed blocks checked against a
// sample-history model every output cycle, plus hand-computed literal sequences.
module tb_lpc_residual_decoder;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic               iLoad;
  logic [3:0]         iM;
  logic signed [11:0] iCoeff;
  logic               iStart;
  logic [3:0]         iOrder;
  logic [3:0]         iShift;
  logic [15:0]        iBlockSize;
  logic               iValid;
  logic signed [15:0] iResidual;
  logic signed [15:0] oSample;
  logic               oValid;
  logic               oDone;
  logic               oBusy;

  lpc_residual_decoder dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad),
    .iM(iM), .iCoeff(iCoeff), .iStart(iStart), .iOrder(iOrder),
    .iShift(iShift), .iBlockSize(iBlockSize), .iValid(iValid),
    .iResidual(iResidual), .oSample(oSample), .oValid(oValid),
    .oDone(oDone), .oBusy(oBusy)
  );

  always #5 iClock = ~iClock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: coefficients, the samples of the current block, and block parameters.
  int     m_coef [12];
  int     m_past [$];
  int     m_order, m_shift, m_bs;
  bit     m_active;
  int     exp_sample [$];
  bit     exp_done   [$];
  int     got [$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare process: every output cycle is matched against the model's expectations.
  always @(negedge iClock) begin
    if (oValid) begin
      got.push_back(int'(oSample));
      if (exp_sample.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("sample", int'(oSample), exp_sample.pop_front());
        check("done", int'(oDone), int'(exp_done.pop_front()));
      end
    end else if (oDone) begin
      check("done_without_valid", 1, 0);
    end
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic load(input int m, input int c);
    iLoad = 1'b1; iM = 4'(m); iCoeff = 12'(c);
    if (!m_active && m >= 1 && m <= 12) m_coef[m-1] = c;
    tick();
    iLoad = 1'b0;
  endtask

  task automatic start(input int order, input int shift, input int bs);
    iStart = 1'b1; iOrder = 4'(order); iShift = 4'(shift); iBlockSize = 16'(bs);
    if (!m_active && order <= 12 && bs != 0) begin
      m_active = 1'b1; m_order = order; m_shift = shift; m_bs = bs;
      m_past.delete();
    end
    tick();
    iStart = 1'b0;
  endtask

  // Model: first `order` samples verbatim, then residual + floor(sum c[j]*x[n-j] / 2^shift), wrapped.
  task automatic send(input int r);
    longint acc;
    longint s;
    iValid = 1'b1; iResidual = 16'(r);
    if (m_active && iEnable) begin
      if (m_past.size() < m_order) begin
        s = r;
      end else begin
        acc = 0;
        for (int j = 1; j <= m_order; j++)
          acc += longint'(m_coef[j-1]) * longint'(m_past[m_past.size()-j]);
        s = longint'(r) + (acc >>> m_shift);
        s = longint'(shortint'(s));
      end
      m_past.push_back(int'(s));
      exp_sample.push_back(int'(s));
      exp_done.push_back(m_past.size() == m_bs);
      if (m_past.size() == m_bs) m_active = 1'b0;
    end
    tick();
    iValid = 1'b0;
  endtask

  task automatic expect_lits(input string name, input int n, input int e0, input int e1,
                             input int e2, input int e3, input int e4, input int e5);
    int e [6];
    e = '{e0, e1, e2, e3, e4, e5};
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check(name, got[i], e[i]);
    got.delete();
  endtask

  initial begin
    iReset = 1'b1; iEnable = 1'b1; iLoad = 1'b0; iM = '0; iCoeff = '0;
    iStart = 1'b0; iOrder = '0; iShift = '0; iBlockSize = '0;
    iValid = 1'b0; iResidual = '0;
    m_active = 1'b0; m_order = 0; m_shift = 0; m_bs = 0;
    for (int i = 0; i < 12; i++) m_coef[i] = 0;
    tick(); tick();
    iReset = 1'b0;
    check("rst_sample", int'(oSample), 0);
    check("rst_valid", int'(oValid), 0);
    check("rst_done", int'(oDone), 0);
    check("rst_busy", int'(oBusy), 0);
    tick();

    // Order 1 integrator.
    load(1, 1);
    start(1, 0, 4);
    check("busy_after_start", int'(oBusy), 1);
    send(100); send(5); send(-3); send(2);
    check("busy_at_done", int'(oBusy), 1);
    tick();
    check("busy_after_done", int'(oBusy), 0);
    expect_lits("t1", 4, 100, 105, 102, 104, 0, 0);

    // Order 2 linear extrapolation, back-to-back.
    load(1, 2); load(2, -1);
    start(2, 0, 5);
    send(10); send(20); send(0); send(0); send(0);
    tick(); tick();
    expect_lits("t2", 5, 10, 20, 30, 40, 50, 0);

    // Shift with floor rounding.
    load(1, 3);
    start(1, 1, 3);
    send(10); send(0); send(1);
    tick(); tick();
    start(1, 1, 2);
    send(-10); send(0);
    tick(); tick();
    expect_lits("t3", 5, 10, 15, 23, -10, -15, 0);

    // Order 0 pass-through and rejected starts.
    start(0, 0, 3);
    send(7); send(-8); send(9);
    tick(); tick();
    expect_lits("t4", 3, 7, -8, 9, 0, 0, 0);
    start(13, 0, 4);
    check("busy_order13", int'(oBusy), 0);
    send(1);
    start(1, 0, 0);
    check("busy_bs0", int'(oBusy), 0);
    send(1);
    tick();
    expect_lits("t4_ignored", 0, 0, 0, 0, 0, 0, 0);

    // Two's-complement wrap.
    load(1, 1);
    start(1, 0, 2);
    send(32767); send(1);
    tick(); tick();
    expect_lits("t5", 2, 32767, -32768, 0, 0, 0, 0);

    // Stall, load during RUN, and start mid-block must not disturb the stream.
    load(1, 2); load(2, -1);
    start(2, 0, 6);
    send(10); send(20); send(0);
    iEnable = 1'b0; iValid = 1'b1; iResidual = 16'(99);
    tick(); tick();
    iValid = 1'b0; iEnable = 1'b1;
    send(0);
    load(1, 5);
    send(0);
    start(1, 0, 3);
    send(0);
    tick(); tick();
    expect_lits("t6", 6, 10, 20, 30, 40, 50, 60);

    // Reset mid-block: abort with no oDone, then a fresh block works.
    start(2, 0, 6);
    send(1); send(2);
    tick();
    iReset = 1'b1;
    m_active = 1'b0;
    tick();
    iReset = 1'b0;
    check("midrst_sample", int'(oSample), 0);
    check("midrst_valid", int'(oValid), 0);
    check("midrst_done", int'(oDone), 0);
    check("midrst_busy", int'(oBusy), 0);
    tick();
    start(1, 0, 1);
    send(42);
    tick(); tick();
    expect_lits("t7", 3, 1, 2, 42, 0, 0, 0);

    tick(); tick();
    check("drain", exp_sample.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_residual_decoder.md
# lpc_residual_decoder

Decoder-side counterpart of the encoder's fixed-order FIR predictor bank. The block rebuilds PCM samples from a stream of LPC residuals: the first `order` samples of a subframe pass through as verbatim warm-up, and every later sample is residual plus the quantised linear prediction of its history. It sits between the residual (Rice) decoder and the channel/PCM output stage.

## Interface
- MAX_ORDER, 12, maximum predictor order; history depth and coefficient count.
- SAMPLE_W, 16, residual and sample width, signed.
- COEFF_W, 12, quantised coefficient width, signed.
- iClock  in  1  clock.
- iReset  in  1  reset; synchronous, active-high.
- iEnable  in  1  global stall; low freezes all state.
- iLoad  in  1  coefficient write strobe.
- iM  in  4  coefficient index, 1..12; other values make the write a no-op.
- iCoeff  in  COEFF_W  signed coefficient value.
- iStart  in  1  begin subframe; latches iOrder, iShift, iBlockSize.
- iOrder  in  4  predictor order, 0..12.
- iShift  in  4  quantisation shift, 0..15.
- iBlockSize  in  16  samples in subframe, 1..65535.
- iValid  in  1  iResidual valid.
- iResidual  in  SAMPLE_W  signed residual, or the verbatim sample during warm-up.
- oSample  out  SAMPLE_W  reconstructed signed sample.
- oValid  out  1  oSample valid.
- oDone  out  1  pulse with the last sample of the subframe.
- oBusy  out  1  high from an accepted iStart until the cycle after oDone.

## Operation
- **Coefficient bank.**
  - 12 signed registers c[1..12]; the write c[iM] <= iCoeff happens on iLoad && iEnable.
  - Writes are honoured only when oBusy is 0; otherwise they are ignored.
  - iLoad and iStart in the same IDLE cycle: the write takes effect, then the block starts.
- **States.** IDLE, WARMUP, RUN.
- **iStart acceptance.** iStart is accepted only in IDLE with iEnable high, iOrder <= 12 and iBlockSize != 0. Otherwise it is ignored and the block stays in IDLE.
- **On an accepted iStart:**
  - history h[1..12] is cleared to 0;
  - the sample counter is cleared;
  - the next state is WARMUP if iOrder > 0, otherwise RUN.
- **Accepted input:** iValid && iEnable in WARMUP or RUN. iValid is ignored in IDLE.
- **WARMUP.** oSample = iResidual. Transition to RUN once `order` samples have been accepted.
- **RUN.**
  - Prediction: acc = sum over j = 1..order of c[j]*h[j], where h[1] is the most recent sample. Terms with j > order contribute 0.
  - Products are 28-bit signed; acc is 32-bit signed.
  - pred = acc >>> shift (arithmetic shift).
  - oSample = (iResidual + pred) truncated to SAMPLE_W bits, two's-complement wrap.
- **History update.** Every accepted input shifts the history: h[1] <= new sample, h[k] <= h[k-1].
- **Termination.**
  - When the sample count reaches iBlockSize, oDone pulses and the state returns to IDLE.
  - This check applies in WARMUP too, so a block size smaller than the order ends during warm-up.
- **iStart while busy:** ignored.
- **iEnable low:**
  - no state, history, counter or coefficient update;
  - oValid and oDone are driven 0 that cycle;
  - oSample holds.

## Timing
- **Reset values:** oSample = 0, oValid = 0, oDone = 0, oBusy = 0, state IDLE. All coefficients, history and counters are 0.
- **Reset mid-subframe** aborts immediately; no oDone is issued.
- **Latency:** 1 cycle. An input accepted at edge n gives oSample/oValid registered at edge n+1.
- **Throughput:** 1 sample per cycle. The full prediction is single-cycle combinational from the registered history, so back-to-back iValid is supported with no bubbles.
- **oValid** is high for exactly one cycle per accepted input.
- **oDone** rises coincident with the final oValid.
- **oBusy:**
  - rises the cycle after the accepted iStart;
  - falls the cycle after oDone;
  - a new iStart is accepted in the same cycle that oBusy falls.
- **iStart + iValid in the same cycle:** iValid is ignored, since the block is still in IDLE.

## Test plan
- Order 1, c1=1, shift 0, block 4, residuals 100,5,-3,2 → samples 100,105,102,104; oDone with the 4th; oBusy low one cycle later.
- Order 2, c1=2, c2=-1, shift 0, block 5, inputs 10,20,0,0,0 → 10,20,30,40,50, back-to-back with no gaps.
- Shift rounding, order 1, c1=3, shift 1:
  - warm-up 10, residuals 0,1 → 10,15,23;
  - new block with warm-up -10, residual 0 → -15 (floor, not toward zero).
- Order 0, block 3, residuals 7,-8,9 → 7,-8,9; oDone on the 3rd. Order 13 or block size 0 → iStart ignored; oBusy stays 0.
- Wrap: order 1, c1=1, warm-up 32767, residual 1 → -32768.
- Control boundaries:
  - iEnable low for 2 cycles mid-RUN → the output sequence is unchanged, merely delayed.
  - iLoad during RUN → no effect on the outputs.
  - iStart mid-block → ignored.
  - iReset mid-block → all outputs 0, IDLE, no oDone.
